// File: rtl/fpu_pkg.sv
// Shared FP16 definitions: class codes, field widths and the result-queue entry format.
// Imported by the classifier and by the result queue.
package fpu_pkg;

    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam logic [EXP_W-1:0] EXP_ALL_ONES = 5'h1F;
    localparam logic [15:0] QNAN_VAL = 16'h7E00;

    typedef logic [2:0] fp_cls_t;

    localparam fp_cls_t FP_CLS_ZERO = 3'd0;
    localparam fp_cls_t FP_CLS_SUB  = 3'd1;
    localparam fp_cls_t FP_CLS_NORM = 3'd2;
    localparam fp_cls_t FP_CLS_INF  = 3'd3;
    localparam fp_cls_t FP_CLS_QNAN = 3'd4;
    localparam fp_cls_t FP_CLS_SNAN = 3'd5;

    typedef struct packed {
        fp_cls_t     cls;
        logic [15:0] value;
    } fpu_entry_t;

    // One-hot-ish sticky flag contribution {nan, inf, sub, zero}; normal sets nothing.
    function automatic logic [3:0] cls_to_flags(input fp_cls_t cls);
        logic [3:0] f;
        f = 4'b0000;
        case (cls)
            FP_CLS_ZERO: f = 4'b0001;
            FP_CLS_SUB:  f = 4'b0010;
            FP_CLS_INF:  f = 4'b0100;
            FP_CLS_QNAN,
            FP_CLS_SNAN: f = 4'b1000;
            default:     f = 4'b0000;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/fpu_result_queue_if.sv
// Producer/host side of the FP16 result queue: multiplier push strobe, host pop/clear
// and the read-back/status signals. master = host + multiplier, slave = queue.
interface fpu_result_queue_if #(
    parameter int DEPTH = 4
);
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic              in_valid;
    logic [15:0]       in_result;
    logic              pop;
    logic              clear;
    logic              rd_valid;
    logic [15:0]       rd_data;
    logic [2:0]        rd_class;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              overrun;
    logic              underrun;
    logic [3:0]        flags;

    modport master (
        output in_valid, in_result, pop, clear,
        input  rd_valid, rd_data, rd_class, count, full, overrun, underrun, flags
    );

    modport slave (
        input  in_valid, in_result, pop, clear,
        output rd_valid, rd_data, rd_class, count, full, overrun, underrun, flags
    );

endinterface

// File: rtl/fpu_classify.sv
// Combinational FP16 classifier; sign is ignored. Shared by the multiplier result
// queue and later adder/converter stages.
module fpu_classify
    import fpu_pkg::*;
(
    input  logic [15:0] value_i,
    output fp_cls_t     cls_o
);

    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;
    logic             unused_sign;

    assign exp_f       = value_i[14:10];
    assign man_f       = value_i[9:0];
    assign unused_sign = value_i[15];

    always_comb begin
        cls_o = FP_CLS_NORM;
        if (exp_f == '0) begin
            cls_o = (man_f == '0) ? FP_CLS_ZERO : FP_CLS_SUB;
        end else if (exp_f == EXP_ALL_ONES) begin
            if (man_f == '0) begin
                cls_o = FP_CLS_INF;
            end else if (man_f[MAN_W-1]) begin
                cls_o = FP_CLS_QNAN;
            end else begin
                cls_o = FP_CLS_SNAN;
            end
        end
    end

endmodule

// File: rtl/fpu_result_queue.sv
// FIFO that buffers classified FP16 multiplier results for the host, with sticky
// overrun/underrun and optional class flags (enable with FPU_RESQ_CLASS_FLAGS_EN).
module fpu_result_queue
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fpu_result_queue_if.slave    q
);

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [ADDR_W-1:0] ptr_t;
    typedef logic [ADDR_W:0]   cnt_t;

    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

    fpu_entry_t mem_q [DEPTH];
    fpu_entry_t head;

    ptr_t    rd_ptr_q, rd_ptr_d;
    ptr_t    wr_ptr_q, wr_ptr_d;
    cnt_t    count_q, count_d;
    logic    overrun_q, overrun_d;
    logic    underrun_q, underrun_d;
    fp_cls_t in_cls;
    logic    empty, is_full;
    logic    push_ok, pop_ok;

    fpu_classify u_classify (
        .value_i (q.in_result),
        .cls_o   (in_cls)
    );

    assign empty   = (count_q == '0);
    assign is_full = (count_q == DEPTH_C);
    assign pop_ok  = q.pop && !empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push_ok = q.in_valid && (!is_full || pop_ok);

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overrun_d  = overrun_q;
        underrun_d = underrun_q;
        if (q.clear) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            overrun_d  = 1'b0;
            underrun_d = 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + ptr_t'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + ptr_t'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + cnt_t'(1);
                2'b01:   count_d = count_q - cnt_t'(1);
                default: count_d = count_q;
            endcase
            if (q.in_valid && !push_ok) begin
                overrun_d = 1'b1;
            end
            if (q.pop && empty) begin
                underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
        end
    end

    // Storage is not reset; the outputs are masked by count while empty.
    always_ff @(posedge clk) begin
        if (push_ok && !q.clear) begin
            mem_q[wr_ptr_q] <= '{cls: in_cls, value: q.in_result};
        end
    end

    assign head = mem_q[rd_ptr_q];

    assign q.rd_valid = !empty;
    assign q.rd_data  = empty ? 16'h0000 : head.value;
    assign q.rd_class = empty ? FP_CLS_ZERO : head.cls;
    assign q.count    = count_q;
    assign q.full     = is_full;
    assign q.overrun  = overrun_q;
    assign q.underrun = underrun_q;

`ifdef FPU_RESQ_CLASS_FLAGS_EN
    logic [3:0] flags_q, flags_d;

    always_comb begin
        flags_d = flags_q;
        if (q.clear) begin
            flags_d = 4'b0000;
        end else if (push_ok) begin
            flags_d = flags_q | cls_to_flags(in_cls);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign q.flags = flags_q;
`else
    assign q.flags = 4'b0000;
`endif

endmodule

// File: tb/tb_fpu_result_queue.sv
// Directed bench for fpu_result_queue (DEPTH=4); expected values are hand-computed.
module tb_fpu_result_queue;

    localparam int DEPTH = 4;
`ifdef FPU_RESQ_CLASS_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    fpu_result_queue_if #(.DEPTH(DEPTH)) bus ();

    fpu_result_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.in_result = 16'h0000;
        bus.pop       = 1'b0;
        bus.clear     = 1'b0;
    endtask

    task automatic push(input logic [15:0] v);
        bus.in_valid  = 1'b1;
        bus.in_result = v;
        step();
        idle();
    endtask

    task automatic pop_one();
        bus.pop = 1'b1;
        step();
        idle();
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        step();
        idle();
    endtask

    logic [15:0] vec4 [4];
    logic [2:0]  cls4 [4];
    logic [15:0] wrap_v [7];

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        idle();
        step();
        step();

        chk("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("reset_rd_data",  32'(bus.rd_data),  32'h0);
        chk("reset_rd_class", 32'(bus.rd_class), 32'd0);
        chk("reset_count",    32'(bus.count),    32'd0);
        chk("reset_full",     32'(bus.full),     32'd0);
        chk("reset_overrun",  32'(bus.overrun),  32'd0);
        chk("reset_underrun", 32'(bus.underrun), 32'd0);
        chk("reset_flags",    32'(bus.flags),    32'd0);
        rst_n = 1'b1;
        step();

        // single push then pop
        push(16'h4200);
        chk("p1_rd_valid", 32'(bus.rd_valid), 32'd1);
        chk("p1_rd_data",  32'(bus.rd_data),  32'h4200);
        chk("p1_rd_class", 32'(bus.rd_class), 32'd2);
        chk("p1_count",    32'(bus.count),    32'd1);
        pop_one();
        chk("p1_pop_valid", 32'(bus.rd_valid), 32'd0);
        chk("p1_pop_data",  32'(bus.rd_data),  32'h0);
        chk("p1_pop_count", 32'(bus.count),    32'd0);

        // four classes back to back
        vec4[0] = 16'h0000; cls4[0] = 3'd0;
        vec4[1] = 16'h0001; cls4[1] = 3'd1;
        vec4[2] = 16'h7C00; cls4[2] = 3'd3;
        vec4[3] = 16'h7E00; cls4[3] = 3'd4;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_result = vec4[i];
            step();
        end
        idle();
        chk("cls_full",  32'(bus.full),  32'd1);
        chk("cls_count", 32'(bus.count), 32'd4);
        chk("cls_flags", 32'(bus.flags), FLAGS_EN ? 32'hF : 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("cls_head_data",  32'(bus.rd_data),  32'(vec4[i]));
            chk("cls_head_class", 32'(bus.rd_class), 32'(cls4[i]));
            pop_one();
        end
        chk("cls_empty_valid", 32'(bus.rd_valid), 32'd0);
        chk("cls_flags_sticky", 32'(bus.flags), FLAGS_EN ? 32'hF : 32'h0);
        do_clear();
        chk("clr_flags", 32'(bus.flags), 32'h0);

        // overrun: fifth push dropped
        vec4[0] = 16'h3800; vec4[1] = 16'h4000; vec4[2] = 16'h4400; vec4[3] = 16'h4800;
        for (int i = 0; i < 4; i++) push(vec4[i]);
        chk("ovr_pre", 32'(bus.overrun), 32'd0);
        push(16'h3C00);
        chk("ovr_set",   32'(bus.overrun), 32'd1);
        chk("ovr_count", 32'(bus.count),   32'd4);
        chk("ovr_head",  32'(bus.rd_data), 32'h3800);
        for (int i = 0; i < 4; i++) begin
            chk("ovr_drain", 32'(bus.rd_data), 32'(vec4[i]));
            pop_one();
        end
        chk("ovr_drained", 32'(bus.rd_valid), 32'd0);
        chk("ovr_sticky",  32'(bus.overrun),  32'd1);
        do_clear();
        chk("ovr_cleared", 32'(bus.overrun), 32'd0);

        // push + pop while full
        vec4[0] = 16'h5000; vec4[1] = 16'h5400; vec4[2] = 16'h5800; vec4[3] = 16'h5C00;
        for (int i = 0; i < 4; i++) push(vec4[i]);
        bus.in_valid  = 1'b1;
        bus.in_result = 16'h7D00;
        bus.pop       = 1'b1;
        step();
        idle();
        chk("fpp_count",   32'(bus.count),   32'd4);
        chk("fpp_overrun", 32'(bus.overrun), 32'd0);
        chk("fpp_flags",   32'(bus.flags),   FLAGS_EN ? 32'h8 : 32'h0);
        for (int i = 1; i < 4; i++) begin
            chk("fpp_drain", 32'(bus.rd_data), 32'(vec4[i]));
            pop_one();
        end
        chk("fpp_last_data",  32'(bus.rd_data),  32'h7D00);
        chk("fpp_last_class", 32'(bus.rd_class), 32'd5);
        pop_one();
        chk("fpp_empty", 32'(bus.count), 32'd0);
        do_clear();

        // underrun, push+pop on empty, push+clear
        pop_one();
        chk("und_set",   32'(bus.underrun), 32'd1);
        chk("und_count", 32'(bus.count),    32'd0);
        bus.in_valid  = 1'b1;
        bus.in_result = 16'h8000;
        bus.clear     = 1'b1;
        step();
        idle();
        chk("pclr_count",    32'(bus.count),    32'd0);
        chk("pclr_underrun", 32'(bus.underrun), 32'd0);
        chk("pclr_valid",    32'(bus.rd_valid), 32'd0);
        chk("pclr_flags",    32'(bus.flags),    32'h0);
        bus.in_valid  = 1'b1;
        bus.in_result = 16'h8000;
        bus.pop       = 1'b1;
        step();
        idle();
        chk("epp_count",    32'(bus.count),    32'd1);
        chk("epp_underrun", 32'(bus.underrun), 32'd1);
        chk("epp_data",     32'(bus.rd_data),  32'h8000);
        chk("epp_class",    32'(bus.rd_class), 32'd0);
        do_clear();

        // async reset mid-burst, then wrap through six push/pop cycles
        push(16'h3000);
        push(16'h3100);
        push(16'h3200);
        chk("ar_pre_count", 32'(bus.count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_count", 32'(bus.count),    32'd0);
        chk("ar_valid", 32'(bus.rd_valid), 32'd0);
        chk("ar_data",  32'(bus.rd_data),  32'h0);
        chk("ar_class", 32'(bus.rd_class), 32'd0);
        #2;
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 7; i++) wrap_v[i] = 16'h2000 + 16'(i * 16'h0111);
        push(wrap_v[0]);
        for (int i = 1; i < 7; i++) begin
            chk("wrap_head",  32'(bus.rd_data), 32'(wrap_v[i-1]));
            chk("wrap_count", 32'(bus.count),   32'd1);
            bus.in_valid  = 1'b1;
            bus.in_result = wrap_v[i];
            bus.pop       = 1'b1;
            step();
            idle();
        end
        chk("wrap_last", 32'(bus.rd_data), 32'(wrap_v[6]));
        pop_one();
        chk("wrap_end_count", 32'(bus.count),    32'd0);
        chk("wrap_underrun",  32'(bus.underrun), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
